// File: rtl/word_receiver_pkg.sv
// word_receiver_pkg
//   Shared defaults for the bootloader word receiver, plus a width helper
//   used to size its internal counters.
package word_receiver_pkg;

  localparam int DEF_WORD_W         = 32;
  localparam int DEF_ADDR_W         = 12;
  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_TIMEOUT_CYCLES = 65536;

  // Bits needed to count 0..n-1. Never returns less than 1, so a degenerate
  // n (0 or 1) still yields a legal vector width.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_receiver_if.sv
// word_receiver_if
//   Groups the bootloader link pins and the memory write port.
//   master : host/memory side (drives dataOnPin/dataPin, sees out/addr/ready)
//   slave  : the receiver (samples the link, produces out/addr/ready)
//   dataOnPin : serial strobe, one bit per rising edge (async to clk)
//   dataPin   : serial data bit (async to clk)
//   out       : last completed word
//   addr      : word address of out
//   ready     : one-cycle write strobe for out/addr
interface word_receiver_if #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 12
);
  logic              dataOnPin;
  logic              dataPin;
  logic [WORD_W-1:0] out;
  logic [ADDR_W-1:0] addr;
  logic              ready;

  modport master (output dataOnPin, output dataPin,
                  input  out, input addr, input ready);
  modport slave  (input  dataOnPin, input dataPin,
                  output out, output addr, output ready);
endinterface

// File: rtl/word_receiver_bit_sync.sv
// bit_sync
//   N-stage flip-flop synchronizer for a single asynchronous input.
//   clk   : destination clock
//   reset : async active-low, clears every stage
//   d     : asynchronous input
//   q     : synchronized output, STAGES clk cycles behind d
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/word_receiver.sv
// word_receiver
//   Bootloader serial-to-parallel receiver. Collects WORD_W bits (LSB first)
//   from a host strobe/data link and presents each finished word to memory
//   with a one-cycle ready pulse and an auto-incrementing word address.
//   clk   : system clock
//   reset : async active-low reset
//   bus   : link pins in, memory write port out (slave modport)
//   A partial word is dropped if no strobe arrives for TIMEOUT_CYCLES clk
//   cycles (0 disables this).
module word_receiver
  import word_receiver_pkg::*;
#(
  parameter int WORD_W         = DEF_WORD_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           reset,
  word_receiver_if.slave bus
);

  localparam int CNT_W = cnt_width(WORD_W);
  localparam int TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [TO_W-1:0]  TO_LAST  =
    (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  // Strobe and data share one stage count so a bit is stable in the synced
  // domain by the time its strobe edge shows up there.
  logic strobe_s, data_s, strobe_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk(clk), .reset(reset), .d(bus.dataOnPin), .q(strobe_s));

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .reset(reset), .d(bus.dataPin), .q(data_s));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) strobe_d <= 1'b0;
    else        strobe_d <= strobe_s;
  end

  logic strobe_edge;
  assign strobe_edge = strobe_s & ~strobe_d;

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bitcnt;
  logic [TO_W-1:0]   to_cnt;
  logic              word_done;

  // Right shift: after WORD_W captures the first bit sits in bit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      bitcnt    <= '0;
      to_cnt    <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (strobe_edge) begin
        shreg  <= {data_s, shreg[WORD_W-1:1]};
        to_cnt <= '0;
        if (bitcnt == CNT_LAST) begin
          bitcnt    <= '0;
          word_done <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 1'b1;
        end
      end else if ((TIMEOUT_CYCLES > 0) && (bitcnt != '0)) begin
        // Host went quiet mid-word: drop the partial word.
        if (to_cnt == TO_LAST) begin
          bitcnt <= '0;
          shreg  <= '0;
          to_cnt <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  logic [WORD_W-1:0] out_q;
  logic [ADDR_W-1:0] addr_q;
  logic              ready_q;

  // addr advances after the pulse so it is stable while ready is high and
  // then already names the next word's slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= word_done;
      if (word_done) out_q  <= shreg;
      if (ready_q)   addr_q <= addr_q + 1'b1;
    end
  end

  assign bus.out   = out_q;
  assign bus.addr  = addr_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_word_receiver.sv
module tb_word_receiver;

  localparam int WORD_W = 32;
  localparam int ADDR_W = 2;
  localparam int SYNC   = 2;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  word_receiver_if #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) bus ();

  word_receiver #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [WORD_W-1:0] w;
    logic [ADDR_W-1:0] a;
    int                stamp;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_pushed = 0;
  int   n_pulse  = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model: words are just consecutive groups of WORD_W bits
  // since the last reset or timeout; slots are numbered modulo 2^ADDR_W.
  logic [WORD_W-1:0] m_word;
  int                m_nbits;
  int                m_addr;

  task automatic model_clear_partial();
    m_word  = '0;
    m_nbits = 0;
  endtask

  task automatic send_bit(input logic b);
    exp_t e;
    @(posedge clk); #1 bus.dataPin = b;
    repeat (3) @(posedge clk);
    #1 bus.dataOnPin = 1'b1;
    m_word[m_nbits] = b;
    m_nbits++;
    if (m_nbits == WORD_W) begin
      e.w = m_word;
      e.a = ADDR_W'(m_addr);
      e.stamp = cyc;
      exp_q.push_back(e);
      n_pushed++;
      m_addr = (m_addr + 1) % (1 << ADDR_W);
      model_clear_partial();
    end
    repeat (3) @(posedge clk);
    #1 bus.dataOnPin = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    for (int i = 0; i < WORD_W; i++) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    if (n >= TO) model_clear_partial();
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    model_clear_partial();
    m_addr = 0;
    #40 reset = 1'b1;
  endtask

  // Monitor: compares every cycle, independent of the stimulus thread.
  logic [WORD_W-1:0] last_out  = '0;
  logic [ADDR_W-1:0] next_addr = '0;

  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0) begin
      chk("reset_out",   bus.out,   0);
      chk("reset_addr",  bus.addr,  0);
      chk("reset_ready", bus.ready, 0);
      last_out  = '0;
      next_addr = '0;
    end else if (bus.ready === 1'b1) begin
      n_pulse++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("word_out",  bus.out,  e.w);
        chk("word_addr", bus.addr, 32'(e.a));
        n_checks++;
        if ((cyc - e.stamp) < SYNC + 1 || (cyc - e.stamp) > SYNC + 3) begin
          n_err++;
          $display("FAIL latency: got %0d cycles want %0d..%0d", cyc - e.stamp, SYNC + 1, SYNC + 3);
        end
        next_addr = e.a + 1'b1;
      end
      last_out = bus.out;
    end else begin
      chk("hold_out",  bus.out,   last_out);
      chk("idle_addr", bus.addr,  32'(next_addr));
      chk("idle_ready", bus.ready, 0);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [63:0] stream;
  logic [31:0] rw;
  int          k;

  initial begin
    reset = 1'b0;
    bus.dataOnPin = 1'b0;
    bus.dataPin   = 1'b0;
    m_addr = 0;
    model_clear_partial();
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    idle(10);

    // Two words back to back.
    stream = {32'h2F7A07FF, 32'h2F000001};
    send_word(stream[31:0]);
    send_word(stream[63:32]);
    idle(10);

    // Reset in the middle of a stream, then resend it.
    do_reset();
    for (int i = 0; i < 40; i++) send_bit(stream[i]);
    do_reset();
    idle(3);
    for (int i = 0; i < 64; i++) send_bit(stream[i]);
    idle(10);

    // Partial word discarded by the idle timeout.
    do_reset();
    idle(3);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    idle(20);
    send_word(32'hA5A5A5A5);
    idle(10);

    // Address wrap with a 2-bit address.
    do_reset();
    idle(3);
    for (int i = 0; i < 5; i++) send_word(32'(i));
    idle(10);

    // Random words, some preceded by an abandoned partial word.
    for (int n = 0; n < 6; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, WORD_W - 1);
        for (int i = 0; i < k; i++) send_bit(1'($urandom));
        idle(20);
      end
      rw = $urandom;
      send_word(rw);
      idle($urandom_range(0, 5));
    end

    idle(20);
    chk("leftover_expected", exp_q.size(), 0);
    chk("pulse_count", n_pulse, n_pushed);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
